mm_final_sub: RTL and testbench

Word-serial final conditional-subtraction stage, directly downstream of the Montgomery PE chain in the ECC arithmetic unit.
- Collects the NUM_WORDS result words (plus the final top carry bit) as the PE chain produces them.
- Computes the result minus the prime p word by word, with a borrow chain, while collecting.
- Streams out the reduced result, always in [0, p), LSW first, over a valid/ready handshake.

---
 rtl/mm_final_sub.sv | 132 +++++++++++++
 tb/tb_mm_final_sub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mm_final_sub.sv
// Word-serial final conditional subtraction for Montgomery results.
// Collects NUM_WORDS result words (LSW first) plus a top carry bit. While it
// collects, it also builds (result - p) through a borrow chain. It then streams
// out either the raw or the subtracted words, so the output always lies in [0, p).
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input word handshake
//   in_word, in_p_word    result word and matching prime word, LSW first
//   in_carry              result bit RADIX*NUM_WORDS, sampled with the last word
//   out_valid/out_ready   output word handshake
//   out_word              reduced result word, LSW first
//   out_last              marks the most-significant output word
module mm_final_sub #(
  parameter int unsigned RADIX     = 32,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RADIX-1:0] in_word,
  input  logic [RADIX-1:0] in_p_word,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RADIX-1:0] out_word,
  output logic             out_last
);

  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_OUTPUT  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             borrow, borrow_nxt;
  logic             sel_diff, sel_diff_nxt;
  logic             in_ready_nxt, out_valid_nxt, out_last_nxt;
  logic             buf_we;
  logic             in_beat, out_beat;
  logic [RADIX:0]   sub_full;

  logic [RADIX-1:0] raw_buf  [NUM_WORDS];
  logic [RADIX-1:0] diff_buf [NUM_WORDS];

  // One step of the (result - p) borrow chain; the MSB is the outgoing borrow.
  assign sub_full = {1'b0, in_word} - {1'b0, in_p_word} - (RADIX+1)'(borrow);

  assign in_beat  = in_valid & in_ready;
  assign out_beat = out_valid & out_ready;

  // Output word is selected straight from the buffers; forced to zero when idle.
  assign out_word = out_valid ? (sel_diff ? diff_buf[cnt] : raw_buf[cnt]) : '0;

  // State, counter, borrow and handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_COLLECT;
      cnt       <= '0;
      borrow    <= 1'b0;
      sel_diff  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      borrow    <= borrow_nxt;
      sel_diff  <= sel_diff_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
    end
  end

  // Word buffers carry no reset; their contents are only read after a full collect.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      raw_buf[cnt]  <= in_word;
      diff_buf[cnt] <= sub_full[RADIX-1:0];
    end
  end

  // Next-state and flag logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    borrow_nxt   = borrow;
    sel_diff_nxt = sel_diff;
    buf_we       = 1'b0;

    case (state)
      ST_COLLECT: begin
        if (in_beat) begin
          buf_we     = 1'b1;
          borrow_nxt = sub_full[RADIX];
          cnt_nxt    = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
            // Subtract when the value reaches 2^n (carry) or did not underflow.
            sel_diff_nxt = in_carry | ~sub_full[RADIX];
            borrow_nxt   = 1'b0;
            cnt_nxt      = '0;
            state_nxt    = ST_OUTPUT;
          end
        end
      end
      ST_OUTPUT: begin
        if (out_beat) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LAST_IDX) begin
            cnt_nxt   = '0;
            state_nxt = ST_COLLECT;
          end
        end
      end
      default: begin
        state_nxt = ST_COLLECT;
        cnt_nxt   = '0;
      end
    endcase

    in_ready_nxt  = (state_nxt == ST_COLLECT);
    out_valid_nxt = (state_nxt == ST_OUTPUT);
    out_last_nxt  = (state_nxt == ST_OUTPUT) && (cnt_nxt == LAST_IDX);
  end

endmodule

// File: tb/tb_mm_final_sub.sv
// Directed bench for mm_final_sub: a RADIX=8/NUM_WORDS=2 instance with
// hand-computed vectors (p = 0xF1FB) plus a default-size instance driven with
// random operands below 2p and checked against a whole-value reference.
module tb_mm_final_sub;

  logic clk = 1'b0;
  logic reset_n;

  logic       s_in_valid, s_in_ready, s_in_carry, s_out_valid, s_out_ready, s_out_last;
  logic [7:0] s_in_word, s_in_p_word, s_out_word;

  logic        b_in_valid, b_in_ready, b_in_carry, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_word, b_in_p_word, b_out_word;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mm_final_sub #(.RADIX(8), .NUM_WORDS(2)) u_small (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_word(s_in_word),
    .in_p_word(s_in_p_word), .in_carry(s_in_carry),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_word(s_out_word),
    .out_last(s_out_last)
  );

  mm_final_sub #(.RADIX(32), .NUM_WORDS(8)) u_big (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_word(b_in_word),
    .in_p_word(b_in_p_word), .in_carry(b_in_carry),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_word(b_out_word),
    .out_last(b_out_last)
  );

  task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends two words against p = 0xF1FB; entered and left on a falling edge.
  task automatic s_send(input logic [7:0] w0, input logic [7:0] w1,
                        input logic c0, input logic c1, input int gap);
    s_in_valid = 1'b1; s_in_word = w0; s_in_p_word = 8'hFB; s_in_carry = c0;
    @(negedge clk);
    if (gap > 0) begin
      s_in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        chk("s_gap_no_output", 260'(s_out_valid), 260'(0));
        @(negedge clk);
      end
    end
    s_in_valid = 1'b1; s_in_word = w1; s_in_p_word = 8'hF1; s_in_carry = c1;
    @(negedge clk);
    s_in_valid = 1'b0; s_in_carry = 1'b0;
  endtask

  // Receives two words; returns them as {MSW, LSW} and the two out_last flags.
  task automatic s_recv(output logic [15:0] val, output logic [1:0] lasts);
    logic [7:0] w [2];
    logic [1:0] l;
    int t;
    s_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (s_out_valid !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("s_recv_timeout", 260'(t < 50), 260'(1));
      w[i] = s_out_word;
      l[i] = s_out_last;
      @(negedge clk);
    end
    s_out_ready = 1'b0;
    val   = {w[1], w[0]};
    lasts = l;
  endtask

  logic [15:0]  s_val;
  logic [1:0]   s_lasts;
  logic [255:0] p;
  logic [257:0] twop, rnd, val, expv, got;
  logic         last_ok;
  int           nrecv, t;

  initial begin
    reset_n = 1'b0;
    s_in_valid = 1'b0; s_in_word = '0; s_in_p_word = '0; s_in_carry = 1'b0; s_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_word = '0; b_in_p_word = '0; b_in_carry = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_s_flags", 260'({s_in_ready, s_out_valid, s_out_last}), 260'(3'b100));
    chk("rst_s_word", 260'(s_out_word), 260'(0));
    chk("rst_b_flags", 260'({b_in_ready, b_out_valid, b_out_last, b_out_word}), 260'({3'b100, 32'h0}));
    reset_n = 1'b1;
    @(negedge clk);

    // Result below p, with latency and out_last checks
    s_send(8'h34, 8'h12, 1'b0, 1'b0, 0);
    chk("below_latency", 260'({s_out_valid, s_in_ready}), 260'(2'b10));
    s_recv(s_val, s_lasts);
    chk("below_val", 260'(s_val), 260'(16'h1234));
    chk("below_last", 260'(s_lasts), 260'(2'b10));
    chk("below_back_to_collect", 260'({s_in_ready, s_out_valid}), 260'(2'b10));

    // Result equal to p
    s_send(8'hFB, 8'hF1, 1'b0, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("equal_val", 260'(s_val), 260'(16'h0000));

    // Result above p
    s_send(8'h00, 8'hF2, 1'b0, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("above_val", 260'(s_val), 260'(16'h0005));

    // Top carry set: 0x10010 - 0xF1FB = 0x0E15
    s_send(8'h10, 8'h00, 1'b0, 1'b1, 0);
    s_recv(s_val, s_lasts);
    chk("carry_val", 260'(s_val), 260'(16'h0E15));

    // Carry on word 0 only is ignored
    s_send(8'h10, 8'h00, 1'b1, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("carry_w0_ignored", 260'(s_val), 260'(16'h0010));

    // Backpressure on word 0 while in_valid pulses must not be accepted
    s_send(8'h34, 8'h12, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_in_word = 8'hAA; s_in_p_word = 8'hFB;
      chk("bp_hold", 260'({s_out_valid, s_out_last, s_in_ready, s_out_word}), 260'({3'b100, 8'h34}));
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    s_recv(s_val, s_lasts);
    chk("bp_val", 260'(s_val), 260'(16'h1234));
    s_send(8'h00, 8'hF2, 1'b0, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("bp_nothing_captured", 260'(s_val), 260'(16'h0005));

    // Gaps in in_valid during collect
    s_send(8'h00, 8'hF2, 1'b0, 1'b0, 3);
    s_recv(s_val, s_lasts);
    chk("gap_val", 260'(s_val), 260'(16'h0005));

    // Reset mid-collect drops the partial operand
    s_in_valid = 1'b1; s_in_word = 8'h00; s_in_p_word = 8'hFB;
    @(negedge clk);
    s_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_collect_flags", 260'({s_in_ready, s_out_valid}), 260'(2'b10));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    s_send(8'h34, 8'h12, 1'b0, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("rst_collect_val", 260'(s_val), 260'(16'h1234));

    // Reset during output aborts immediately
    s_send(8'hFB, 8'hF1, 1'b0, 1'b0, 0);
    chk("pre_rst_out_valid", 260'(s_out_valid), 260'(1));
    reset_n = 1'b0;
    #1;
    chk("rst_output_flags", 260'({s_out_valid, s_in_ready, s_out_last, s_out_word}), 260'({3'b010, 8'h00}));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    s_send(8'h34, 8'h12, 1'b0, 1'b0, 0);
    s_recv(s_val, s_lasts);
    chk("rst_output_val", 260'(s_val), 260'(16'h1234));

    // Default-size operands, back to back, against a whole-value reference
    for (int k = 0; k < 1004; k++) begin
      for (int j = 0; j < 8; j++) begin
        p[32*j +: 32]   = $urandom;
        rnd[32*j +: 32] = $urandom;
      end
      rnd[257:256] = 2'($urandom);
      p[0]   = 1'b1;
      p[255] = k[0];
      twop = {1'b0, p, 1'b0};
      case (k)
        0:       val = '0;
        1:       val = {2'b00, p};
        2:       val = {2'b00, p} - 258'(1);
        3:       val = twop - 258'(1);
        default: val = rnd % twop;
      endcase
      expv = (val >= {2'b00, p}) ? val - {2'b00, p} : val;

      for (int w = 0; w < 8; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          b_in_valid = 1'b0;
          @(negedge clk);
        end
        b_in_valid  = 1'b1;
        b_in_word   = val[32*w +: 32];
        b_in_p_word = p[32*w +: 32];
        b_in_carry  = (w == 7) ? val[256] : 1'($urandom);
        @(negedge clk);
      end
      b_in_valid = 1'b0;
      b_in_carry = 1'b0;

      got = '0; nrecv = 0; last_ok = 1'b1; t = 0;
      while (nrecv < 8 && t < 200) begin
        b_out_ready = ($urandom_range(0, 3) != 0);
        if (b_out_valid && b_out_ready) begin
          got[32*nrecv +: 32] = b_out_word;
          if (b_out_last !== (nrecv == 7)) last_ok = 1'b0;
          nrecv++;
        end
        @(negedge clk);
        t++;
      end
      b_out_ready = 1'b0;
      chk("big_word_count", 260'(nrecv), 260'(8));
      chk("big_val", 260'(got), 260'(expv));
      chk("big_last", 260'(last_ok), 260'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
